// File: rtl/csi2_pkt_ctrl_pkg.sv
// Shared types and constants for the CSI-2 packet sequencer.
//   csi2_hdr_t   : packet header word layout {rsvd, ecc, wc, vc, dt}
//   DT_*         : data-type codes of the frame/line sync short packets
//   csi2_state_e : packet sequencer FSM states
//   last_keep()  : byte enables of the final payload word for a given WC
package csi2_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 17;

  typedef struct packed {
    logic [1:0]  rsvd;
    logic [5:0]  ecc;
    logic [15:0] wc;
    logic [1:0]  vc;
    logic [5:0]  dt;
  } csi2_hdr_t;

  localparam logic [5:0] DT_FS        = 6'h00;
  localparam logic [5:0] DT_FE        = 6'h01;
  localparam logic [5:0] DT_LS        = 6'h02;
  localparam logic [5:0] DT_LE        = 6'h03;
  localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_TAIL    = 3'd2,
    ST_DROP    = 3'd3,
    ST_DONE    = 3'd4
  } csi2_state_e;

  // Byte enables for the last payload word given WC mod 4.
  function automatic logic [3:0] last_keep(input logic [1:0] rem);
    logic [3:0] keep;
    case (rem)
      2'd1:    keep = 4'b0001;
      2'd2:    keep = 4'b0011;
      2'd3:    keep = 4'b0111;
      default: keep = 4'b1111;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/csi2_pkt_ctrl.sv
// CSI-2 packet-level sequencer behind the header Hamming decoder.
// Parses the first word of each packet as the header, streams long-packet
// payload with keep/last, decodes FS/FE/LS/LE short packets and issues a
// one-cycle pkt_done_o to re-arm the decoder.
// Ports:
//   clk_i, rst_n_i                 : clock, async active-low reset
//   data_i, valid_i                : word stream from the header decoder
//   error_i, error_corrected_i     : decoder header ECC status (with header)
//   eot_i                          : PHY end-of-transmission pulse
//   pkt_done_o                     : packet delimiter pulse
//   tdata_o/tkeep_o/tvalid_o/tlast_o/tuser_o/tdest_o : payload stream
//   frame_start_o/frame_end_o/line_start_o/line_end_o : sync pulses
//   hdr_err_o, trunc_err_o         : error pulses
//   pkt_cnt_o/hdr_corr_cnt_o/hdr_err_cnt_o : statistics
// Optional statistics counters are built when CSI2_PKT_STAT_EN is defined;
// otherwise the statistics ports read 0.
module csi2_pkt_ctrl
  import csi2_pkg::*;
#(
  parameter logic [3:0]  VC_MASK    = 4'b1111,
  parameter int unsigned STAT_CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [31:0]           data_i,
  input  logic                  valid_i,
  input  logic                  error_i,
  input  logic                  error_corrected_i,
  input  logic                  eot_i,
  output logic                  pkt_done_o,
  output logic [31:0]           tdata_o,
  output logic [3:0]            tkeep_o,
  output logic                  tvalid_o,
  output logic                  tlast_o,
  output logic                  tuser_o,
  output logic [1:0]            tdest_o,
  output logic                  frame_start_o,
  output logic                  frame_end_o,
  output logic                  line_start_o,
  output logic                  line_end_o,
  output logic                  hdr_err_o,
  output logic                  trunc_err_o,
  output logic [STAT_CNT_W-1:0] pkt_cnt_o,
  output logic [STAT_CNT_W-1:0] hdr_corr_cnt_o,
  output logic [STAT_CNT_W-1:0] hdr_err_cnt_o
);

  csi2_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tail_q, tail_d;
  logic [3:0]       keep_last_q, keep_last_d;
  logic [1:0]       vc_q, vc_d;
  logic             acc_q, acc_d;
  logic             fs_pend_q, fs_pend_d;

  logic             pkt_done_q, pkt_done_d;
  logic [31:0]      tdata_q, tdata_d;
  logic [3:0]       tkeep_q, tkeep_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             tuser_q, tuser_d;
  logic             fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic             hdr_err_q, hdr_err_d;
  logic             trunc_q, trunc_d;

  csi2_hdr_t        hdr_c;
  logic [CNT_W-1:0] wc_c, p_words_c, t_words_c;
  logic             unused_hdr_c;

  // Header view of the incoming word and derived word counts.
  assign hdr_c        = csi2_hdr_t'(data_i);
  assign wc_c         = CNT_W'(hdr_c.wc);
  assign p_words_c    = (wc_c + CNT_W'(3)) >> 2;
  assign t_words_c    = (wc_c + CNT_W'(5)) >> 2;
  assign unused_hdr_c = ^{hdr_c.ecc, hdr_c.rsvd};

  // FSM state and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tail_q      <= 1'b0;
      keep_last_q <= '0;
      vc_q        <= '0;
      acc_q       <= 1'b0;
      fs_pend_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      ls_q        <= 1'b0;
      le_q        <= 1'b0;
      hdr_err_q   <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tail_q      <= tail_d;
      keep_last_q <= keep_last_d;
      vc_q        <= vc_d;
      acc_q       <= acc_d;
      fs_pend_q   <= fs_pend_d;
      pkt_done_q  <= pkt_done_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
      ls_q        <= ls_d;
      le_q        <= le_d;
      hdr_err_q   <= hdr_err_d;
      trunc_q     <= trunc_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tail_d      = tail_q;
    keep_last_d = keep_last_q;
    vc_d        = vc_q;
    acc_d       = acc_q;
    fs_pend_d   = fs_pend_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    tuser_d     = 1'b0;
    fs_d        = 1'b0;
    fe_d        = 1'b0;
    ls_d        = 1'b0;
    le_d        = 1'b0;
    hdr_err_d   = 1'b0;
    trunc_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          vc_d  = hdr_c.vc;
          acc_d = VC_MASK[hdr_c.vc];
          if (error_i && !error_corrected_i) begin
            hdr_err_d = 1'b1;
            state_d   = ST_DROP;
          end else if (hdr_c.dt <= DT_SHORT_MAX) begin
            state_d = ST_DONE;
            if (VC_MASK[hdr_c.vc]) begin
              case (hdr_c.dt)
                DT_FS: begin
                  fs_d      = 1'b1;
                  fs_pend_d = 1'b1;
                end
                DT_FE: begin
                  fe_d      = 1'b1;
                  fs_pend_d = 1'b0;
                end
                DT_LS:   ls_d = 1'b1;
                DT_LE:   le_d = 1'b1;
                default: ;
              endcase
            end
          end else if (hdr_c.wc == 16'd0) begin
            // Empty long packet still carries one CRC word.
            state_d = ST_TAIL;
          end else begin
            cnt_d       = p_words_c;
            tail_d      = t_words_c > p_words_c;
            keep_last_d = last_keep(hdr_c.wc[1:0]);
            state_d     = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (valid_i) begin
          tvalid_d = acc_q;
          tlast_d  = acc_q && (cnt_q == CNT_W'(1));
          if (acc_q) begin
            tdata_d   = data_i;
            tkeep_d   = (cnt_q == CNT_W'(1)) ? keep_last_q : 4'hF;
            tuser_d   = fs_pend_q;
            fs_pend_d = 1'b0;
          end
          cnt_d = cnt_q - CNT_W'(1);
          // A final word arriving with eot_i completes the packet normally.
          if (cnt_q == CNT_W'(1)) begin
            state_d = tail_q ? ST_TAIL : ST_DONE;
          end else if (eot_i) begin
            trunc_d = 1'b1;
            state_d = ST_DONE;
          end
        end else if (eot_i) begin
          trunc_d = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_TAIL: begin
        if (valid_i) begin
          state_d = ST_DONE;
        end else if (eot_i) begin
          trunc_d = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DROP: begin
        if (eot_i) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The delimiter is high for the whole single cycle spent in DONE.
  assign pkt_done_d = (state_d == ST_DONE);

  assign pkt_done_o    = pkt_done_q;
  assign tdata_o       = tdata_q;
  assign tkeep_o       = tkeep_q;
  assign tvalid_o      = tvalid_q;
  assign tlast_o       = tlast_q;
  assign tuser_o       = tuser_q;
  assign tdest_o       = vc_q;
  assign frame_start_o = fs_q;
  assign frame_end_o   = fe_q;
  assign line_start_o  = ls_q;
  assign line_end_o    = le_q;
  assign hdr_err_o     = hdr_err_q;
  assign trunc_err_o   = trunc_q;

`ifdef CSI2_PKT_STAT_EN
  logic [STAT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [STAT_CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [STAT_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating statistics counters.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    corr_cnt_d = corr_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (pkt_done_d && (pkt_cnt_q != '1)) begin
      pkt_cnt_d = pkt_cnt_q + STAT_CNT_W'(1);
    end
    if ((state_q == ST_IDLE) && valid_i && error_corrected_i && (corr_cnt_q != '1)) begin
      corr_cnt_d = corr_cnt_q + STAT_CNT_W'(1);
    end
    if (hdr_err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + STAT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pkt_cnt_q  <= '0;
      corr_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      corr_cnt_q <= corr_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign pkt_cnt_o      = pkt_cnt_q;
  assign hdr_corr_cnt_o = corr_cnt_q;
  assign hdr_err_cnt_o  = err_cnt_q;
`else
  assign pkt_cnt_o      = '0;
  assign hdr_corr_cnt_o = '0;
  assign hdr_err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_csi2_pkt_ctrl.sv
// Self-checking bench for csi2_pkt_ctrl: directed packets from the test plan
// followed by randomized packets, each checked cycle by cycle against
// expectations derived from the packet's header (word counts, keep, pulses).
module tb_csi2_pkt_ctrl;

  localparam logic [3:0] TB_VC_MASK = 4'b1011;
  localparam int unsigned SW = 16;
`ifdef CSI2_PKT_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  // Bit positions in the observed pulse vector.
  localparam int B_PD = 9, B_TV = 8, B_TL = 7, B_TU = 6, B_FS = 5;
  localparam int B_FE = 4, B_LS = 3, B_LE = 2, B_HE = 1, B_TR = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   data_i = '0;
  logic          valid_i = 1'b0, error_i = 1'b0, corr_i = 1'b0, eot_i = 1'b0;
  logic          pkt_done, tvalid, tlast, tuser, fs, fe, ls, le, hdr_err, trunc;
  logic [31:0]   tdata;
  logic [3:0]    tkeep;
  logic [1:0]    tdest;
  logic [SW-1:0] pkt_cnt, corr_cnt, err_cnt;

  int checks = 0;
  int failures = 0;
  bit fs_pend = 1'b0;
  int m_pkt = 0, m_corr = 0, m_err = 0;

  always #5 clk = ~clk;

  csi2_pkt_ctrl #(.VC_MASK(TB_VC_MASK), .STAT_CNT_W(SW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .valid_i(valid_i),
    .error_i(error_i), .error_corrected_i(corr_i), .eot_i(eot_i),
    .pkt_done_o(pkt_done), .tdata_o(tdata), .tkeep_o(tkeep), .tvalid_o(tvalid),
    .tlast_o(tlast), .tuser_o(tuser), .tdest_o(tdest),
    .frame_start_o(fs), .frame_end_o(fe), .line_start_o(ls), .line_end_o(le),
    .hdr_err_o(hdr_err), .trunc_err_o(trunc),
    .pkt_cnt_o(pkt_cnt), .hdr_corr_cnt_o(corr_cnt), .hdr_err_cnt_o(err_cnt)
  );

  wire [9:0] pulses = {pkt_done, tvalid, tlast, tuser, fs, fe, ls, le, hdr_err, trunc};

  // One clock of stimulus, then check the registered outputs it produced.
  task automatic step(input logic v, input logic [31:0] d, input logic e, input logic c,
                      input logic eo, input logic [9:0] ep, input logic [31:0] ed,
                      input logic [3:0] ek, input logic [1:0] et, input string tag);
    valid_i = v; data_i = d; error_i = e; corr_i = c; eot_i = eo;
    @(posedge clk);
    #1;
    checks++;
    assert (pulses === ep) else begin
      failures++;
      $error("FAIL %s pulses observed=%b expected=%b", tag, pulses, ep);
    end
    if (ep[B_TV]) begin
      checks++;
      assert ({tdata, tkeep, tdest} === {ed, ek, et}) else begin
        failures++;
        $error("FAIL %s beat observed=%h/%h/%0d expected=%h/%h/%0d",
               tag, tdata, tkeep, tdest, ed, ek, et);
      end
    end
  endtask

  task automatic check_stats(input string tag);
    logic [3*SW-1:0] exp_s;
    exp_s = STAT_EN ? {SW'(m_pkt), SW'(m_corr), SW'(m_err)} : '0;
    checks++;
    assert ({pkt_cnt, corr_cnt, err_cnt} === exp_s) else begin
      failures++;
      $error("FAIL %s stats observed=%0d/%0d/%0d expected=%0d/%0d/%0d", tag,
             pkt_cnt, corr_cnt, err_cnt, exp_s[3*SW-1:2*SW], exp_s[2*SW-1:SW], exp_s[SW-1:0]);
    end
  endtask

  // Drive one whole packet; trunc_at = word index (after header) replaced by eot.
  task automatic send_pkt(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc,
                          input logic err, input logic corr, input int trunc_at,
                          input bit eot_last, input int n_junk, input bit gaps,
                          input string tag);
    logic [31:0] hdr, w;
    logic [9:0]  ep;
    logic [3:0]  ek;
    bit          acc, hard, short_pkt;
    int          p_words, t_words;
    acc       = TB_VC_MASK[vc];
    hard      = err && !corr;
    short_pkt = (dt <= 6'h0F);
    p_words   = (int'(wc) + 3) / 4;
    t_words   = (int'(wc) + 5) / 4;
    hdr       = {2'b00, 6'($urandom), wc, vc, dt};
    ep        = '0;
    if (hard) begin
      ep[B_HE] = 1'b1;
    end else if (short_pkt) begin
      ep[B_PD] = 1'b1;
      if (acc) begin
        if (dt == 6'h00) begin ep[B_FS] = 1'b1; fs_pend = 1'b1; end
        else if (dt == 6'h01) begin ep[B_FE] = 1'b1; fs_pend = 1'b0; end
        else if (dt == 6'h02) ep[B_LS] = 1'b1;
        else if (dt == 6'h03) ep[B_LE] = 1'b1;
      end
    end
    if (err && corr) m_corr++;
    if (hard) m_err++;
    step(1'b1, hdr, err, corr, 1'b0, ep, '0, '0, '0, {tag, ":hdr"});

    if (hard) begin
      for (int j = 0; j < n_junk; j++)
        step(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, '0, '0, '0, {tag, ":junk"});
      ep = '0; ep[B_PD] = 1'b1;
      step(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 1'b1, ep, '0, '0, '0, {tag, ":eot"});
    end else if (!short_pkt) begin
      for (int i = 1; i <= t_words; i++) begin
        if (gaps && ($urandom_range(0, 3) == 0))
          step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, {tag, ":gap"});
        ep = '0;
        if (i == trunc_at) begin
          ep[B_PD] = 1'b1; ep[B_TR] = 1'b1;
          step(1'b0, $urandom, 1'b0, 1'b0, 1'b1, ep, '0, '0, '0, {tag, ":trunc"});
          break;
        end
        w  = $urandom;
        ek = 4'hF;
        if ((i <= p_words) && acc) begin
          ep[B_TV] = 1'b1;
          ep[B_TU] = fs_pend;
          fs_pend  = 1'b0;
          if (i == p_words) begin
            ep[B_TL] = 1'b1;
            if ((wc % 4) != 0) ek = 4'((1 << (wc % 4)) - 1);
          end
        end
        if (i == t_words) ep[B_PD] = 1'b1;
        step(1'b1, w, 1'b0, 1'b0, eot_last && (i == t_words), ep, w, ek, vc, {tag, ":word"});
      end
    end
    m_pkt++;
    // Input arriving during the delimiter cycle must be ignored.
    step(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
         '0, '0, '0, '0, {tag, ":done"});
    check_stats(tag);
  endtask

  initial begin
    logic [5:0]  r_dt;
    logic [15:0] r_wc;
    logic        r_err, r_corr;
    int          r_tr, sel;
    bit          r_eot;

    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert ({pulses, tdata, tkeep, tdest, pkt_cnt, corr_cnt, err_cnt} === '0) else begin
      failures++;
      $error("FAIL reset outputs observed=%b/%h expected=0", pulses, tdata);
    end
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, '0, '0, '0, '0, "idle_eot");

    send_pkt(6'h2B, 2'd0, 16'd8,  1'b0, 1'b0, -1, 1'b0, 0, 1'b0, "wc8");
    send_pkt(6'h2B, 2'd0, 16'd5,  1'b0, 1'b0, -1, 1'b0, 0, 1'b0, "wc5");
    send_pkt(6'h00, 2'd1, 16'd0,  1'b0, 1'b0, -1, 1'b0, 0, 1'b0, "fs");
    send_pkt(6'h2B, 2'd1, 16'd4,  1'b0, 1'b0, -1, 1'b0, 0, 1'b0, "tuser");
    send_pkt(6'h02, 2'd1, 16'd0,  1'b0, 1'b0, -1, 1'b0, 0, 1'b0, "ls");
    send_pkt(6'h03, 2'd3, 16'd0,  1'b0, 1'b0, -1, 1'b0, 0, 1'b0, "le");
    send_pkt(6'h01, 2'd1, 16'd0,  1'b0, 1'b0, -1, 1'b0, 0, 1'b0, "fe");
    send_pkt(6'h2B, 2'd0, 16'd8,  1'b1, 1'b0, -1, 1'b0, 5, 1'b0, "hdrerr");
    send_pkt(6'h2B, 2'd2, 16'd4,  1'b0, 1'b0, -1, 1'b0, 0, 1'b0, "vcmask");
    send_pkt(6'h2B, 2'd0, 16'd16, 1'b0, 1'b0, 3,  1'b0, 0, 1'b0, "trunc");
    send_pkt(6'h2B, 2'd3, 16'd12, 1'b0, 1'b0, -1, 1'b0, 0, 1'b0, "after_trunc");
    send_pkt(6'h2C, 2'd1, 16'd7,  1'b1, 1'b1, -1, 1'b0, 0, 1'b0, "corrected");
    send_pkt(6'h2C, 2'd1, 16'd6,  1'b0, 1'b0, -1, 1'b1, 0, 1'b0, "eot_last");
    send_pkt(6'h2A, 2'd0, 16'd0,  1'b0, 1'b0, -1, 1'b0, 0, 1'b0, "wc0");
    send_pkt(6'h00, 2'd0, 16'd0,  1'b0, 1'b0, -1, 1'b0, 0, 1'b0, "fs2");
    send_pkt(6'h01, 2'd3, 16'd0,  1'b0, 1'b0, -1, 1'b0, 0, 1'b0, "fe_clr");
    send_pkt(6'h24, 2'd0, 16'd3,  1'b0, 1'b0, -1, 1'b0, 0, 1'b1, "wc3");

    for (int n = 0; n < 80; n++) begin
      sel    = int'($urandom_range(0, 3));
      r_dt   = (sel == 0) ? 6'($urandom_range(0, 15)) : 6'($urandom_range(16, 63));
      r_wc   = (sel == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
      sel    = int'($urandom_range(0, 9));
      r_err  = (sel < 2);
      r_corr = (sel == 1);
      r_tr   = -1;
      if ($urandom_range(0, 6) == 0) r_tr = int'($urandom_range(1, (int'(r_wc) + 5) / 4));
      r_eot  = (r_tr < 0) && ($urandom_range(0, 2) == 0);
      send_pkt(r_dt, 2'($urandom), r_wc, r_err, r_corr, r_tr, r_eot,
               int'($urandom_range(0, 4)), 1'b1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
